// File: rtl/edge_event_arbiter.sv
// Rising-edge detector and round-robin arbiter that funnels N level inputs
// onto one valid/ready event port carrying the channel number.
module edge_event_arbiter #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in,
    input  logic [N-1:0]    en,
    input  logic            evt_ready,
    input  logic            clr_overrun,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic [N-1:0]    overrun
);

    logic [N-1:0]    prev_in;
    logic            primed;
    logic [N-1:0]    pending;
    logic [ID_W-1:0] last;

    logic [N-1:0]    edge_det;
    logic [N-1:0]    grant_clr;
    logic [N-1:0]    pending_nxt;
    logic [N-1:0]    overrun_nxt;
    logic            load;
    logic            found;
    logic [ID_W-1:0] grant_id;

    // Handshake: an event transfers on any posedge with evt_valid & evt_ready;
    // while evt_valid & ~evt_ready the register holds evt_valid/evt_id unchanged.
    assign load = ~evt_valid | evt_ready;

    // The first clock after reset only captures the input levels.
    assign edge_det = primed ? (in & ~prev_in & en) : '0;

    // Round-robin: channels above last are searched first, then wrap to 0..last.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && pending[i] && (i > int'(last))) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && pending[i] && (i <= int'(last))) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        grant_clr = '0;
        if (load && found) begin
            grant_clr = {{(N-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    // An edge on the channel being granted this cycle re-arms it instead of overrunning.
    assign pending_nxt = en & ((pending & ~grant_clr) | edge_det);
    assign overrun_nxt = (clr_overrun ? '0 : overrun) | (edge_det & pending & ~grant_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_in   <= '0;
            primed    <= 1'b0;
            pending   <= '0;
            last      <= ID_W'(N - 1);
            evt_valid <= 1'b0;
            evt_id    <= '0;
            overrun   <= '0;
        end else begin
            prev_in <= in;
            primed  <= 1'b1;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            if (load) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_id    <= grant_id;
                    last      <= grant_id;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: expected channel IDs go into a queue,
// a negedge monitor pops them on every transfer, and direct checks cover the rest.
module tb_edge_event_arbiter;

    localparam int N    = 8;
    localparam int ID_W = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_v;
    logic [N-1:0]    en;
    logic            evt_ready;
    logic            clr_overrun;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic [N-1:0]    overrun;

    logic [ID_W-1:0] exp_q[$];
    int              n_cmp;
    int              n_bad;

    edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_v),
        .en          (en),
        .evt_ready   (evt_ready),
        .clr_overrun (clr_overrun),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .overrun     (overrun)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [ID_W-1:0] exp_id;
        if (!rst && evt_valid && evt_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected: got id %0d, required no event", evt_id);
            end else begin
                exp_id = exp_q.pop_front();
                if (evt_id !== exp_id) begin
                    n_bad++;
                    $display("FAIL evt_id: got %0d, required %0d", evt_id, exp_id);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic push3(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b,
                         input logic [ID_W-1:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    // Reset with a given input level held through it, then the priming clock.
    task automatic do_reset(input logic [N-1:0] lvl);
        in_v = lvl;
        rst  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_drain();
        int budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        in_v        = '0;
        en          = 8'hFF;
        evt_ready   = 1'b1;
        clr_overrun = 1'b0;
        #12;
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_id", 32'(evt_id), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // Single edge on channel 3
        do_reset(8'h00);
        in_v = 8'h08;
        exp_q.push_back(3'd3);
        cyc();
        check("single_not_yet", 32'(evt_valid), 32'd0);
        cyc();
        check("single_event", {evt_valid, evt_id}, {1'b1, 3'd3});
        cyc();
        check("single_one_cycle", 32'(evt_valid), 32'd0);
        check("single_overrun", 32'(overrun), 32'd0);
        in_v = 8'h00;
        cyc();
        cyc();

        // Round-robin fairness, twice
        do_reset(8'h00);
        for (int r = 0; r < 2; r++) begin
            in_v = 8'h85;
            push3(3'd0, 3'd2, 3'd7);
            cyc();
            cyc();
            check("rr_first", {evt_valid, evt_id}, {1'b1, 3'd0});
            cyc();
            check("rr_second", {evt_valid, evt_id}, {1'b1, 3'd2});
            cyc();
            check("rr_third", {evt_valid, evt_id}, {1'b1, 3'd7});
            cyc();
            check("rr_idle", 32'(evt_valid), 32'd0);
            in_v = 8'h00;
            cyc();
        end

        // Backpressure on channels 1 and 5
        evt_ready = 1'b0;
        in_v      = 8'h22;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            check("bp_hold", {evt_valid, evt_id}, {1'b1, 3'd1});
            cyc();
        end
        evt_ready = 1'b1;
        cyc();
        check("bp_second", {evt_valid, evt_id}, {1'b1, 3'd5});
        cyc();
        check("bp_idle", 32'(evt_valid), 32'd0);
        wait_drain();

        // Overrun: channel 0 occupies the output, channel 4 edges twice while pending
        evt_ready = 1'b0;
        in_v = 8'h00;
        cyc();
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd4);
        in_v = 8'h01; cyc();
        in_v = 8'h01; cyc();
        in_v = 8'h11; cyc();
        in_v = 8'h01; cyc();
        in_v = 8'h11; cyc();
        check("ovr_flag", 32'(overrun), 32'h10);
        check("ovr_hold", {evt_valid, evt_id}, {1'b1, 3'd0});
        evt_ready = 1'b1;
        cyc();
        check("ovr_single_4", {evt_valid, evt_id}, {1'b1, 3'd4});
        cyc();
        check("ovr_idle", 32'(evt_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'h10);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h00);
        wait_drain();

        // Clear coincident with a new overrun on channel 4
        evt_ready = 1'b0;
        in_v = 8'h00;
        cyc();
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd4);
        in_v = 8'h01; cyc();
        in_v = 8'h01; cyc();
        in_v = 8'h11; cyc();
        in_v = 8'h01; cyc();
        in_v = 8'h11; clr_overrun = 1'b1; cyc();
        clr_overrun = 1'b0;
        check("ovr_clr_race", 32'(overrun), 32'h10);
        evt_ready = 1'b1;
        wait_drain();
        cyc();
        cyc();

        // Priming: in[6] held high through reset gives nothing
        do_reset(8'h40);
        cyc(); cyc(); cyc();
        check("prime_no_event", 32'(evt_valid), 32'd0);
        // Disabled channel 2 ignores its edge
        en   = 8'hFB;
        in_v = 8'h44;
        cyc(); cyc(); cyc();
        check("en_masked", 32'(evt_valid), 32'd0);
        en = 8'hFF;
        cyc(); cyc();
        check("en_reenable_quiet", 32'(evt_valid), 32'd0);
        // Dropping en[5] while pending discards the request
        evt_ready = 1'b0;
        in_v = 8'h45;
        exp_q.push_back(3'd0);
        cyc();
        cyc();
        in_v = 8'h65;
        cyc();
        en = 8'hDF;
        cyc();
        en        = 8'hFF;
        evt_ready = 1'b1;
        cyc();
        check("en_drop_idle", 32'(evt_valid), 32'd0);
        cyc();
        check("en_drop_idle2", 32'(evt_valid), 32'd0);
        wait_drain();

        // Reset mid-operation
        in_v = 8'h00;
        cyc();
        evt_ready = 1'b0;
        in_v = 8'h04; cyc();
        cyc();
        in_v = 8'h34; cyc();
        in_v = 8'h04; cyc();
        in_v = 8'h14; cyc();
        check("mid_pre_event", {evt_valid, evt_id}, {1'b1, 3'd2});
        check("mid_pre_overrun", 32'(overrun), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_id", 32'(evt_id), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        evt_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc(); cyc(); cyc();
        check("mid_post_quiet", 32'(evt_valid), 32'd0);
        in_v = 8'h00;
        cyc();
        in_v = 8'h80;
        exp_q.push_back(3'd7);
        cyc();
        cyc();
        check("mid_new_event", {evt_valid, evt_id}, {1'b1, 3'd7});
        cyc();
        check("mid_new_idle", 32'(evt_valid), 32'd0);
        wait_drain();
        cyc(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
